// File: rtl/clkdiv_pkg.sv
// Shared constants and channel state type for the clkdiv_multi divider bank.
package clkdiv_pkg;
    localparam int NUM_CH_MAX = 16;
    localparam int DIV_W_DEF  = 8;
    localparam int FRAC_W_DEF = 4;
    localparam int MIN_DIV    = 2;

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ch_state_t;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/clkdiv_multi_if.sv
// Config write channel of clkdiv_multi: valid/ready handshake carrying channel, ratio and fraction.
interface clkdiv_multi_if #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = clkdiv_pkg::DIV_W_DEF,
    parameter int FRAC_W = clkdiv_pkg::FRAC_W_DEF
) ();
    import clkdiv_pkg::*;
    localparam int CH_W = ch_width(NUM_CH);

    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic [FRAC_W-1:0] cfg_frac;

    modport master (output cfg_valid, cfg_ch, cfg_div, cfg_frac, input cfg_ready);
    modport slave  (input cfg_valid, cfg_ch, cfg_div, cfg_frac, output cfg_ready);
endinterface

// File: rtl/clkdiv_chan.sv
// One divider channel: phase counter, shadowed ratio, STOP/RUN/DRAIN FSM.
// Optional fractional dither accumulator is built when CLKDIV_DITHER_EN is defined.
module clkdiv_chan import clkdiv_pkg::*; #(
    parameter int DIV_W       = DIV_W_DEF,
    parameter int FRAC_W      = FRAC_W_DEF,
    parameter int DEFAULT_DIV = 2
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              ch_en,
    input  logic              sync,
    input  logic              wr,
    input  logic [DIV_W-1:0]  wr_div,
    input  logic [FRAC_W-1:0] wr_frac,
    output logic              clk_out,
    output logic              tick,
    output logic              busy
);
    ch_state_t        state, state_nxt;
    logic [DIV_W-1:0] k, k_nxt, ratio, ratio_nxt, shd_div, last_k;
    logic [DIV_W:0]   half;
    logic             extra, extra_nxt, busy_nxt, clk_nxt, tick_nxt;
    logic             apply, adv, clr_acc, carry;

    // A dither period appends one cycle after k = N-1.
    assign last_k = ratio - DIV_W'(1) + DIV_W'(extra);

    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        state_nxt = state;
        k_nxt     = k;
        ratio_nxt = ratio;
        extra_nxt = extra;
        apply     = 1'b0;
        adv       = 1'b0;
        clr_acc   = 1'b0;
        half      = '0;
        unique case (state)
            STOP: begin
                apply     = busy;
                k_nxt     = '0;
                extra_nxt = 1'b0;
                if (ch_en) state_nxt = RUN;
            end
            RUN, DRAIN: begin
                state_nxt = ch_en ? RUN : DRAIN;
                if (sync) begin
                    apply     = busy;
                    clr_acc   = 1'b1;
                    k_nxt     = '0;
                    extra_nxt = 1'b0;
                end else if (k == last_k) begin
                    apply = busy;
                    k_nxt = '0;
                    if (ch_en) begin
                        adv       = 1'b1;
                        extra_nxt = carry;
                    end else begin
                        state_nxt = STOP;
                        extra_nxt = 1'b0;
                    end
                end else begin
                    k_nxt = k + DIV_W'(1);
                end
            end
            default: state_nxt = STOP;
        endcase
        if (apply) ratio_nxt = shd_div;
        busy_nxt = (busy && !apply) || wr;
        half     = ({1'b0, ratio_nxt} + (DIV_W + 1)'(1)) >> 1;
        clk_nxt  = (state_nxt != STOP) && ({1'b0, k_nxt} < half);
        tick_nxt = (state_nxt != STOP) && (k_nxt == '0);
    end

    always_ff @(posedge clk_in) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (rst) begin
            state   <= STOP;
            k       <= '0;
            ratio   <= DIV_W'(DEFAULT_DIV);
            shd_div <= DIV_W'(DEFAULT_DIV);
            extra   <= 1'b0;
            busy    <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            state   <= state_nxt;
            k       <= k_nxt;
            ratio   <= ratio_nxt;
            extra   <= extra_nxt;
            busy    <= busy_nxt;
            clk_out <= clk_nxt;
            tick    <= tick_nxt;
            if (wr) shd_div <= (wr_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : wr_div;
        end
    end

`ifdef CLKDIV_DITHER_EN
    logic [FRAC_W-1:0] frac, shd_frac, acc;
    logic [FRAC_W:0]   acc_sum;

    // At a boundary a pending shadow is applied, so its fraction drives the carry.
    assign acc_sum = {1'b0, acc} + {1'b0, busy ? shd_frac : frac};
    assign carry   = acc_sum[FRAC_W];

    always_ff @(posedge clk_in) begin
        if (rst) begin
            frac     <= '0;
            shd_frac <= '0;
            acc      <= '0;
        end else begin
            if (wr)    shd_frac <= wr_frac;
            if (apply) frac     <= shd_frac;
            if (clr_acc)  acc <= '0;
            else if (adv) acc <= acc_sum[FRAC_W-1:0];
        end
    end
`else
    logic unused_dither;
    assign carry         = 1'b0;
    assign unused_dither = ^{wr_frac, adv, clr_acc};
`endif
endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable integer clock divider: config decode plus NUM_CH clkdiv_chan instances.
// Fractional dither is enabled with the CLKDIV_DITHER_EN macro.
module clkdiv_multi import clkdiv_pkg::*; #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = DIV_W_DEF,
    parameter int FRAC_W      = FRAC_W_DEF,
    parameter int DEFAULT_DIV = 2
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    clkdiv_multi_if.slave     cfg,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] busy
);
    localparam int CH_W = ch_width(NUM_CH);

    logic [NUM_CH-1:0] hit, wr;
    logic              ready;

    // An out-of-range channel matches no bit, so it is accepted and dropped.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_CH; i++) hit[i] = (cfg.cfg_ch == CH_W'(i));
    end

    assign ready         = !rst && !(|(hit & busy));
    assign cfg.cfg_ready = ready;
    assign wr            = hit & {NUM_CH{cfg.cfg_valid && ready}};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clkdiv_chan #(
            .DIV_W      (DIV_W),
            .FRAC_W     (FRAC_W),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_chan (
            .clk_in (clk_in),
            .rst    (rst),
            .ch_en  (ch_en[g]),
            .sync   (sync),
            .wr     (wr[g]),
            .wr_div (cfg.cfg_div),
            .wr_frac(cfg.cfg_frac),
            .clk_out(clk_out[g]),
            .tick   (tick[g]),
            .busy   (busy[g])
        );
    end
endmodule

// File: tb/tb_clkdiv_multi.sv
// Self-checking bench for clkdiv_multi: directed scenarios plus randomized traffic against a period-level model.
module tb_clkdiv_multi;
    localparam int NCH = 3;
    localparam int DW  = 8;
    localparam int FW  = 4;

    logic           clk_in = 1'b0;
    logic           rst    = 1'b1;
    logic           sync   = 1'b0;
    logic [NCH-1:0] ch_en  = '0;
    logic [NCH-1:0] clk_out, tick, busy;
    int             checks = 0;
    int             errors = 0;

    clkdiv_multi_if #(.NUM_CH(NCH), .DIV_W(DW), .FRAC_W(FW)) cfg_if ();

    clkdiv_multi #(.NUM_CH(NCH), .DIV_W(DW), .FRAC_W(FW), .DEFAULT_DIV(2)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .ch_en  (ch_en),
        .sync   (sync),
        .cfg    (cfg_if),
        .clk_out(clk_out),
        .tick   (tick),
        .busy   (busy)
    );

    always #5 clk_in = ~clk_in;

    // Model: each channel is a running flag, a position inside a period of known length, and a pending ratio.
    bit m_run [NCH];
    bit m_pend[NCH];
    int m_pos [NCH];
    int m_len [NCH];
    int m_n   [NCH];
    int m_f   [NCH];
    int m_acc [NCH];
    int m_pn  [NCH];
    int m_pf  [NCH];

    function automatic bit exp_ready();
        int c;
        c = int'(cfg_if.cfg_ch);
        if (rst) return 1'b0;
        if (c >= NCH) return 1'b1;
        return !m_pend[c];
    endfunction

    function automatic logic [3*NCH-1:0] exp_outs();
        logic [NCH-1:0] c, t, b;
        for (int i = 0; i < NCH; i++) begin
            c[i] = m_run[i] && (m_pos[i] < (m_n[i] + 1) / 2);
            t[i] = m_run[i] && (m_pos[i] == 0);
            b[i] = m_pend[i];
        end
        return {c, t, b};
    endfunction

    task automatic take_shadow(input int i);
        if (m_pend[i]) begin
            m_n[i]    = m_pn[i];
            m_f[i]    = m_pf[i];
            m_pend[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input bit r, input logic [NCH-1:0] en, input bit s,
                              input bit v, input int ch, input int d, input int f);
        for (int i = 0; i < NCH; i++) begin
            bit taken;
            int carry;
            taken = v && (ch == i) && !m_pend[i];
            if (r) begin
                m_run[i] = 0; m_pend[i] = 0; m_pos[i] = 0; m_len[i] = 2;
                m_n[i] = 2; m_f[i] = 0; m_acc[i] = 0; m_pn[i] = 2; m_pf[i] = 0;
                continue;
            end
            if (!m_run[i]) begin
                take_shadow(i);
                if (en[i]) begin
                    m_run[i] = 1; m_pos[i] = 0; m_len[i] = m_n[i];
                end
            end else if (s) begin
                take_shadow(i);
                m_acc[i] = 0; m_pos[i] = 0; m_len[i] = m_n[i];
            end else if (m_pos[i] == m_len[i] - 1) begin
                take_shadow(i);
                m_pos[i] = 0;
                if (en[i]) begin
                    carry = 0;
`ifdef CLKDIV_DITHER_EN
                    m_acc[i] = m_acc[i] + m_f[i];
                    carry    = m_acc[i] >> FW;
                    m_acc[i] = m_acc[i] % (1 << FW);
`endif
                    m_len[i] = m_n[i] + carry;
                end else begin
                    m_run[i] = 0;
                end
            end else begin
                m_pos[i]++;
            end
            if (taken) begin
                m_pend[i] = 1;
                m_pn[i]   = (d < 2) ? 2 : d;
                m_pf[i]   = f;
            end
        end
    endtask

    task automatic step();
        bit r, s, v;
        logic [NCH-1:0] en;
        int c, d, f;
        r = rst; en = ch_en; s = sync; v = cfg_if.cfg_valid;
        c = int'(cfg_if.cfg_ch); d = int'(cfg_if.cfg_div); f = int'(cfg_if.cfg_frac);
        @(posedge clk_in);
        #1;
        model_edge(r, en, s, v, c, d, f);
    endtask

    task automatic drive_cfg(input int ch, input int div, input int frac);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = ch[1:0];
        cfg_if.cfg_div   = div[DW-1:0];
        cfg_if.cfg_frac  = frac[FW-1:0];
    endtask

    task automatic idle_cfg();
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; ch_en = '0; sync = 1'b0; idle_cfg();
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ch_en = '1; drive_cfg(0, 5, 0);
        #1;
        checks++;
        if (cfg_if.cfg_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got %b want 0", cfg_if.cfg_ready);
        end
        step();
        checks++;
        if ({clk_out, tick, busy} !== '0) begin
            errors++; $display("FAIL reset_outs: got %h want 0", {clk_out, tick, busy});
        end
        rst = 1'b0; ch_en = '0; idle_cfg();
        #1;
        checks++;
        if (cfg_if.cfg_ready !== exp_ready()) begin
            errors++; $display("FAIL reset_ready_rel: got %b want %b", cfg_if.cfg_ready, exp_ready());
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({clk_out, tick, busy} !== '0) begin
                errors++; $display("FAIL reset_idle cycle %0d: got %h want 0", i, {clk_out, tick, busy});
            end
        end
    endtask

    task automatic test_ratio5();
        do_reset();
        drive_cfg(0, 5, 0);
        #1;
        checks++;
        if (cfg_if.cfg_ready !== 1'b1) begin
            errors++; $display("FAIL r5_ready: got %b want 1", cfg_if.cfg_ready);
        end
        step(); idle_cfg(); step();
        ch_en[0] = 1'b1;
        for (int j = 0; j < 15; j++) begin
            step();
            checks++;
            if (clk_out[0] !== ((j % 5) < 3) || tick[0] !== ((j % 5) == 0)) begin
                errors++; $display("FAIL r5_pattern cycle %0d: got clk=%b tick=%b want clk=%b tick=%b",
                                   j, clk_out[0], tick[0], (j % 5) < 3, (j % 5) == 0);
            end
            checks++;
            if ({clk_out, tick, busy} !== exp_outs()) begin
                errors++; $display("FAIL r5_model cycle %0d: got %h want %h", j, {clk_out, tick, busy}, exp_outs());
            end
        end
    endtask

    task automatic test_update();
        bit [8:0] e_clk, e_tick, e_busy;
        e_clk = 9'b100011100; e_tick = 9'b100000100; e_busy = 9'b000000011;
        do_reset();
        drive_cfg(0, 4, 0); step();
        idle_cfg(); ch_en[0] = 1'b1; step(); step();
        drive_cfg(0, 6, 0);
        #1;
        checks++;
        if (cfg_if.cfg_ready !== 1'b1) begin
            errors++; $display("FAIL upd_ready_free: got %b want 1", cfg_if.cfg_ready);
        end
        step(); idle_cfg();
        #1;
        checks++;
        if (cfg_if.cfg_ready !== 1'b0) begin
            errors++; $display("FAIL upd_ready_busy: got %b want 0", cfg_if.cfg_ready);
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (clk_out[0] !== e_clk[i] || tick[0] !== e_tick[i] || busy[0] !== e_busy[i]) begin
                errors++; $display("FAIL upd_seq cycle %0d: got clk=%b tick=%b busy=%b want %b %b %b",
                                   i, clk_out[0], tick[0], busy[0], e_clk[i], e_tick[i], e_busy[i]);
            end
            checks++;
            if ({clk_out, tick, busy} !== exp_outs()) begin
                errors++; $display("FAIL upd_model cycle %0d: got %h want %h", i, {clk_out, tick, busy}, exp_outs());
            end
            step();
        end
    endtask

    task automatic test_drain();
        int kk;
        do_reset();
        drive_cfg(0, 8, 0); step();
        idle_cfg(); ch_en[0] = 1'b1; step(); step();
        ch_en[0] = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step();
            checks++;
            if (clk_out[0] !== (i < 2) || tick[0] !== 1'b0 || {clk_out, tick, busy} !== exp_outs()) begin
                errors++; $display("FAIL drain_stop cycle %0d: got %h want %h (clk0 want %b)",
                                   i, {clk_out, tick, busy}, exp_outs(), i < 2);
            end
        end
        ch_en[0] = 1'b1; step(); step();
        ch_en[0] = 1'b0; step(); step(); step(); step();
        ch_en[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            kk = (6 + i) % 8;
            checks++;
            if (clk_out[0] !== (kk < 4) || tick[0] !== (kk == 0) || {clk_out, tick, busy} !== exp_outs()) begin
                errors++; $display("FAIL drain_resume cycle %0d: got %h want %h (k=%0d)",
                                   i, {clk_out, tick, busy}, exp_outs(), kk);
            end
        end
    endtask

    task automatic test_sync();
        int n;
        do_reset();
        drive_cfg(0, 4, 0); step();
        drive_cfg(1, 6, 0); step();
        idle_cfg(); ch_en = 3'b011; step();
        n = $urandom_range(3, 12);
        for (int i = 0; i < n; i++) begin
            step();
            checks++;
            if ({clk_out, tick, busy} !== exp_outs()) begin
                errors++; $display("FAIL sync_pre cycle %0d: got %h want %h", i, {clk_out, tick, busy}, exp_outs());
            end
        end
        sync = 1'b1; step(); sync = 1'b0;
        checks++;
        if (clk_out !== 3'b011 || tick !== 3'b011) begin
            errors++; $display("FAIL sync_align: got clk=%b tick=%b want 011 011", clk_out, tick);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({clk_out, tick, busy} !== exp_outs()) begin
                errors++; $display("FAIL sync_post cycle %0d: got %h want %h", i, {clk_out, tick, busy}, exp_outs());
            end
            step();
        end
    endtask

    task automatic test_oob_reset();
        do_reset();
        drive_cfg(0, 5, 0); step();
        idle_cfg(); ch_en = 3'b001; step(); step(); step();
        drive_cfg(3, 9, 0);
        #1;
        checks++;
        if (cfg_if.cfg_ready !== 1'b1) begin
            errors++; $display("FAIL oob_ready: got %b want 1", cfg_if.cfg_ready);
        end
        step(); idle_cfg();
        checks++;
        if (busy !== 3'b000 || {clk_out, tick, busy} !== exp_outs()) begin
            errors++; $display("FAIL oob_busy: got busy=%b want 000", busy);
        end
        rst = 1'b1; step(); rst = 1'b0;
        checks++;
        if ({clk_out, tick, busy} !== '0) begin
            errors++; $display("FAIL midrst_outs: got %h want 0", {clk_out, tick, busy});
        end
        step();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (clk_out[0] !== ((i % 2) == 0) || tick[0] !== ((i % 2) == 0)) begin
                errors++; $display("FAIL midrst_div2 cycle %0d: got clk=%b tick=%b want %b",
                                   i, clk_out[0], tick[0], (i % 2) == 0);
            end
            step();
        end
    endtask

    task automatic test_dither();
        int ticks, start, len, want;
        ticks = 0; start = 0; len = -1;
`ifdef CLKDIV_DITHER_EN
        want = 17;
`else
        want = 16;
`endif
        do_reset();
        drive_cfg(0, 4, 4); step();
        idle_cfg(); ch_en[0] = 1'b1;
        for (int c = 0; c < 200 && len < 0; c++) begin
            step();
            checks++;
            if ({clk_out, tick, busy} !== exp_outs()) begin
                errors++; $display("FAIL dither_model cycle %0d: got %h want %h", c, {clk_out, tick, busy}, exp_outs());
            end
            if (tick[0]) begin
                ticks++;
                if (ticks == 2) start = c;
                if (ticks == 6) len = c - start;
            end
        end
        checks++;
        if (len != want) begin
            errors++; $display("FAIL dither_4periods: got %0d cycles want %0d", len, want);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NCH; i++) if ($urandom_range(0, 7) == 0) ch_en[i] = ~ch_en[i];
            sync = ($urandom_range(0, 19) == 0);
            rst  = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 2) == 0)
                drive_cfg($urandom_range(0, 3), $urandom_range(0, 12), $urandom_range(0, 15));
            else
                idle_cfg();
            #1;
            checks++;
            if (cfg_if.cfg_ready !== exp_ready()) begin
                errors++; $display("FAIL rand_ready cycle %0d: got %b want %b", c, cfg_if.cfg_ready, exp_ready());
            end
            step();
            checks++;
            if ({clk_out, tick, busy} !== exp_outs()) begin
                errors++; $display("FAIL rand_outs cycle %0d: got %h want %h", c, {clk_out, tick, busy}, exp_outs());
            end
        end
        rst = 1'b0; sync = 1'b0; idle_cfg();
    endtask

    initial begin
        idle_cfg();
        cfg_if.cfg_ch = '0; cfg_if.cfg_div = '0; cfg_if.cfg_frac = '0;
        step(); step();
        test_reset();
        test_ratio5();
        test_update();
        test_drain();
        test_sync();
        test_oob_reset();
        test_dither();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
